// File: rtl/hstate_if.sv
// Bundle of the tanh/gate inputs and the h output stream for hstate_mul.
// The master drives the operands and h_ready; the slave (hstate_mul) returns comp, h, h_valid, sat and count.
interface hstate_if;
    logic [31:0] tanh;
    logic        en;
    logic        comp;
    logic [31:0] gate;
    logic        gate_valid;
    logic [31:0] h;
    logic        h_valid;
    logic        h_ready;
    logic        sat;
    logic [15:0] count;

    modport master (
        output tanh, en, gate, gate_valid, h_ready,
        input  comp, h, h_valid, sat, count
    );

    modport slave (
        input  tanh, en, gate, gate_valid, h_ready,
        output comp, h, h_valid, sat, count
    );
endinterface

// File: rtl/hstate_mul.sv
// LSTM hidden-state multiply h = gate * tanh in Q5.26, with an IDLE/MULT/SAT/OUT handshake sequence.
// Define HSTATE_SAT_EN to saturate out-of-range products; otherwise h wraps and sat stays 0.
module hstate_mul (
    input  logic      clk,
    input  logic      rst,
    input  logic      locked,
    hstate_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MULT, SAT, OUT} state_t;

    state_t             state_reg, state_next;
    logic signed [31:0] tanh_reg, tanh_next;
    logic signed [31:0] gate_reg, gate_next;
    logic signed [63:0] prod_reg, prod_next;
    logic signed [63:0] prod_full;
    logic        [31:0] h_reg, h_next;
    logic        [31:0] h_calc;
    logic               h_valid_reg, h_valid_next;
    logic               sat_reg, sat_next;
    logic               comp_reg, comp_next;
    logic               ovf;
    logic               count_inc;
    logic        [15:0] count_reg;

    assign prod_full = $signed({{32{tanh_reg[31]}}, tanh_reg}) * $signed({{32{gate_reg[31]}}, gate_reg});

    // Q10.52 product back to Q5.26: keep bits [57:26]; overflow when [63:57] disagree.
`ifdef HSTATE_SAT_EN
    logic unused_prod_bits;
    assign unused_prod_bits = ^prod_reg[25:0];
    assign ovf = !((&prod_reg[63:57]) || !(|prod_reg[63:57]));
`else
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_reg[63:58], prod_reg[25:0]};
    assign ovf = 1'b0;
`endif

    always_comb begin
        if (ovf) begin
            h_calc = prod_reg[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            h_calc = prod_reg[57:26];
        end
    end

    always_comb begin
        state_next   = state_reg;
        tanh_next    = tanh_reg;
        gate_next    = gate_reg;
        prod_next    = prod_reg;
        h_next       = h_reg;
        h_valid_next = h_valid_reg;
        sat_next     = sat_reg;
        comp_next    = 1'b0;
        count_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.en && bus.gate_valid) begin
                    tanh_next  = bus.tanh;
                    gate_next  = bus.gate;
                    comp_next  = 1'b1;
                    state_next = MULT;
                end
            end
            MULT: begin
                prod_next  = prod_full;
                state_next = SAT;
            end
            SAT: begin
                h_next       = h_calc;
                sat_next     = ovf;
                h_valid_next = 1'b1;
                state_next   = OUT;
            end
            OUT: begin
                if (bus.h_ready) begin
                    h_valid_next = 1'b0;
                    count_inc    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // locked behaves as a synchronous twin of rst and wins over every other input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            tanh_reg    <= '0;
            gate_reg    <= '0;
            prod_reg    <= '0;
            h_reg       <= '0;
            h_valid_reg <= 1'b0;
            sat_reg     <= 1'b0;
            comp_reg    <= 1'b0;
            count_reg   <= '0;
        end else if (locked) begin
            state_reg   <= IDLE;
            tanh_reg    <= '0;
            gate_reg    <= '0;
            prod_reg    <= '0;
            h_reg       <= '0;
            h_valid_reg <= 1'b0;
            sat_reg     <= 1'b0;
            comp_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            tanh_reg    <= tanh_next;
            gate_reg    <= gate_next;
            prod_reg    <= prod_next;
            h_reg       <= h_next;
            h_valid_reg <= h_valid_next;
            sat_reg     <= sat_next;
            comp_reg    <= comp_next;
            if (count_inc) begin
                count_reg <= count_reg + 16'd1;
            end
        end
    end

    assign bus.comp    = comp_reg;
    assign bus.h       = h_reg;
    assign bus.h_valid = h_valid_reg;
    assign bus.sat     = sat_reg;
    assign bus.count   = count_reg;
endmodule

// File: tb/tb_hstate_mul.sv
// Self-checking bench for hstate_mul: table of operand vectors through a result scoreboard,
// plus hand sequences for back-pressure, mid-operation rst/locked and count wrap.
`timescale 1ns/1ps
module tb_hstate_mul;
    logic clk = 1'b0;
    logic rst;
    logic locked;

    hstate_if bus ();

    hstate_mul dut (
        .clk    (clk),
        .rst    (rst),
        .locked (locked),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_count = 16'd0;

    typedef struct {
        logic [31:0] h;
        logic        sat;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic [31:0] tanh;
        logic [31:0] gate;
        logic [31:0] h_sat;
        logic        ovf;
        logic [31:0] h_wrap;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
`ifdef HSTATE_SAT_EN
        e.h   = v.h_sat;
        e.sat = v.ovf;
`else
        e.h   = v.h_wrap;
        e.sat = 1'b0;
`endif
        return e;
    endfunction

    // One full transaction; stall = cycles of h_ready=0 in OUT, hold_en keeps en/gate_valid high throughout.
    task automatic do_txn(input vec_t v, input int stall, input bit hold_en);
        exp_t e;
        logic [31:0] h_seen;
        logic        sat_seen;
        bus.tanh       = v.tanh;
        bus.gate       = v.gate;
        bus.en         = 1'b1;
        bus.gate_valid = 1'b1;
        bus.h_ready    = (stall == 0);
        sb_q.push_back(expect_of(v));
        step();
        check({v.name, " comp_after_capture"}, 32'(bus.comp), 32'd1);
        check({v.name, " hvalid_after_capture"}, 32'(bus.h_valid), 32'd0);
        if (!hold_en) begin
            bus.en         = 1'b0;
            bus.gate_valid = 1'b0;
        end
        step();
        check({v.name, " comp_one_cycle"}, 32'(bus.comp), 32'd0);
        check({v.name, " hvalid_early"}, 32'(bus.h_valid), 32'd0);
        step();
        check({v.name, " hvalid_rise"}, 32'(bus.h_valid), 32'd1);
        e = sb_q.pop_front();
        check({v.name, " h"}, bus.h, e.h);
        check({v.name, " sat"}, 32'(bus.sat), 32'(e.sat));
        h_seen   = bus.h;
        sat_seen = bus.sat;
        for (int i = 0; i < stall; i++) begin
            step();
            check({v.name, " stall_hvalid"}, 32'(bus.h_valid), 32'd1);
            check({v.name, " stall_h"}, bus.h, h_seen);
            check({v.name, " stall_sat"}, 32'(bus.sat), 32'(sat_seen));
            check({v.name, " stall_comp"}, 32'(bus.comp), 32'd0);
        end
        bus.h_ready = 1'b1;
        step();
        exp_count = exp_count + 16'd1;
        bus.en         = 1'b0;
        bus.gate_valid = 1'b0;
        check({v.name, " hvalid_clear"}, 32'(bus.h_valid), 32'd0);
        check({v.name, " count"}, 32'(bus.count), 32'(exp_count));
        $display("txn %s tanh=0x%08h gate=0x%08h h=0x%08h sat=%0d count=0x%04h",
                 v.name, v.tanh, v.gate, h_seen, sat_seen, bus.count);
        step();
        check({v.name, " idle_no_comp"}, 32'(bus.comp), 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{"one_x_half",   32'h0400_0000, 32'h0200_0000, 32'h0200_0000, 1'b0, 32'h0200_0000};
        vecs[1] = '{"neg_one",      32'hFC00_0000, 32'h0400_0000, 32'hFC00_0000, 1'b0, 32'hFC00_0000};
        vecs[2] = '{"max_x_max",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFC0};
        vecs[3] = '{"min_x_min",    32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000};
        vecs[4] = '{"min_x_max",    32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0020};
        vecs[5] = '{"pos_32_edge",  32'h4000_0000, 32'h0800_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000};
        vecs[6] = '{"neg_32_exact", 32'hC000_0000, 32'h0800_0000, 32'h8000_0000, 1'b0, 32'h8000_0000};
        vecs[7] = '{"mixed_1p5",    32'h0600_0000, 32'hFA00_0000, 32'hF700_0000, 1'b0, 32'hF700_0000};

        rst = 1'b1;
        locked = 1'b0;
        bus.tanh = '0;
        bus.gate = '0;
        bus.en = 1'b0;
        bus.gate_valid = 1'b0;
        bus.h_ready = 1'b0;
        step();
        check("reset_comp", 32'(bus.comp), 32'd0);
        check("reset_h", bus.h, 32'd0);
        check("reset_hvalid", 32'(bus.h_valid), 32'd0);
        check("reset_sat", 32'(bus.sat), 32'd0);
        check("reset_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.h_ready = 1'b1;
        step();
        check("idle_hready_no_effect", 32'(bus.h_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], 0, 1'b0);
        end

        // Back-pressure with en held high throughout.
        do_txn(vecs[0], 5, 1'b1);

        // Async reset while in SAT.
        bus.tanh = 32'h0400_0000;
        bus.gate = 32'h0200_0000;
        bus.en = 1'b1;
        bus.gate_valid = 1'b1;
        step();
        bus.en = 1'b0;
        bus.gate_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("rst_sat_comp", 32'(bus.comp), 32'd0);
        check("rst_sat_hvalid", 32'(bus.h_valid), 32'd0);
        check("rst_sat_count", 32'(bus.count), 32'd0);
        check("rst_sat_h", bus.h, 32'd0);
        exp_count = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rst_no_partial_hvalid", 32'(bus.h_valid), 32'd0);
        do_txn(vecs[0], 0, 1'b0);

        // locked while stalled in OUT abandons the result.
        bus.tanh = 32'h0400_0000;
        bus.gate = 32'h0400_0000;
        bus.en = 1'b1;
        bus.gate_valid = 1'b1;
        bus.h_ready = 1'b0;
        step();
        bus.en = 1'b0;
        bus.gate_valid = 1'b0;
        step();
        step();
        check("pre_lock_hvalid", 32'(bus.h_valid), 32'd1);
        @(negedge clk);
        locked = 1'b1;
        bus.h_ready = 1'b1;
        bus.en = 1'b1;
        bus.gate_valid = 1'b1;
        step();
        check("lock_hvalid", 32'(bus.h_valid), 32'd0);
        check("lock_count", 32'(bus.count), 32'd0);
        check("lock_comp", 32'(bus.comp), 32'd0);
        check("lock_h", bus.h, 32'd0);
        exp_count = 16'd0;
        @(negedge clk);
        locked = 1'b0;
        bus.en = 1'b0;
        bus.gate_valid = 1'b0;
        step();
        check("unlock_no_comp", 32'(bus.comp), 32'd0);
        do_txn(vecs[1], 0, 1'b0);

        // Count wrap from a preloaded 0xFFFF.
        @(negedge clk);
        force dut.count_reg = 16'hFFFF;
        #1;
        release dut.count_reg;
        #1;
        check("preload_count", 32'(bus.count), 32'h0000_FFFF);
        exp_count = 16'hFFFF;
        v = vecs[7];
        v.name = "count_wrap";
        do_txn(v, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
